// File: rtl/vram_fetch_pkg.sv
// vram_fetch_pkg
//   Shared types and constants for the VRAM fetch sequencer.
//   - vbyte_t         : one pixel/attribute byte as seen by the gate array
//   - BLANK_BYTE      : value pushed into the delay line outside display enable
//   - MAX_DELAY_CHARS : deepest supported delay line, in CRTC characters
//   - idx_width()     : width of a byte-select for a given word size
package vram_fetch_pkg;

  localparam int MAX_DELAY_CHARS = 3;

  typedef logic [7:0] vbyte_t;

  localparam vbyte_t BLANK_BYTE = 8'h00;

  // Byte-select width; never below one bit so a port always exists.
  function automatic int idx_width(input int bpw);
    return (bpw > 1) ? $clog2(bpw) : 1;
  endfunction

endpackage

// File: rtl/vram_delay_line.sv
// vram_delay_line
//   Circular byte buffer of DEPTH entries. A push writes the slot under the
//   write pointer and then advances the pointer, so that slot always holds the
//   oldest entry, i.e. the byte pushed DEPTH pushes ago.
// Ports:
//   clk    - system clock
//   rst_n  - asynchronous active-low reset; clears all entries and pointer
//   push   - write din and advance the pointer
//   din    - byte to store
//   oldest - entry under the write pointer (pre-push value in a push cycle)
module vram_delay_line
  import vram_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  vbyte_t din,
  output vbyte_t oldest
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [DEPTH-1:0][7:0] mem;
  logic [PW-1:0]         wp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '0;
      wp  <= '0;
    end else if (push) begin
      mem[wp] <= din;
      // Depth need not be a power of two, so wrap explicitly.
      wp      <= (wp == LAST) ? '0 : wp + 1'b1;
    end
  end

  assign oldest = mem[wp];

endmodule

// File: rtl/vram_fetch_seq.sv
// vram_fetch_seq
//   Splits each VRAM word into BYTES_PER_WORD sequential byte fetches paced by
//   the gate array RAS_N/CAS_N strobes during video slots (cpu_n high).
//   A byte is captured every cycle RAS and CAS are both low; the rising edge
//   of CAS inside RAS commits it and advances the byte select. In shift mode
//   the committed bytes go through a delay line DELAY_CHARS characters deep
//   and the gate array sees the delayed stream instead.
// Parameters:
//   BYTES_PER_WORD - 2 or 4
//   DELAY_CHARS    - delay-line depth in characters, 1..3
// Optional feature (macro VRAM_FETCH_COUNT_EN):
//   adds vsync input and a saturating 16-bit fetch_count output, cleared on
//   the rising edge of vsync (clear wins over a same-cycle commit).
// Ports:
//   clk, RESET_N      - clock, asynchronous active-low reset
//   cpu_n             - low = CPU slot (forces byte select to 0), high = video
//   ras_n, cas_n      - gate array DRAM strobes
//   de                - CRTC display enable (blanks delay-line pushes when low)
//   shift_en          - 1 = route through delay line, 0 = direct
//   vram_din          - VRAM word, byte k at [8k+7:8k]
//   vram_d            - byte presented to the gate array
//   byte_idx          - current byte select
//   fetch_done        - one-cycle pulse after each committed byte
module vram_fetch_seq
  import vram_fetch_pkg::*;
#(
  parameter int BYTES_PER_WORD = 2,
  parameter int DELAY_CHARS    = 1
) (
  input  logic                                   clk,
  input  logic                                   RESET_N,
  input  logic                                   cpu_n,
  input  logic                                   ras_n,
  input  logic                                   cas_n,
  input  logic                                   de,
  input  logic                                   shift_en,
  input  logic [8*BYTES_PER_WORD-1:0]            vram_din,
`ifdef VRAM_FETCH_COUNT_EN
  input  logic                                   vsync,
  output logic [15:0]                            fetch_count,
`endif
  output vbyte_t                                 vram_d,
  output logic [idx_width(BYTES_PER_WORD)-1:0]   byte_idx,
  output logic                                   fetch_done
);

  localparam int IW = idx_width(BYTES_PER_WORD);
  localparam logic [IW-1:0] LAST_IDX = IW'(BYTES_PER_WORD - 1);
  // Out-of-range depths are clamped rather than building a useless line.
  localparam int DC = (DELAY_CHARS < 1) ? 1 :
                      (DELAY_CHARS > MAX_DELAY_CHARS) ? MAX_DELAY_CHARS : DELAY_CHARS;
  localparam int LINE_LEN = DC * BYTES_PER_WORD;

  // Word split into byte lanes.
  vbyte_t [BYTES_PER_WORD-1:0] lanes;
  for (genvar k = 0; k < BYTES_PER_WORD; k++) begin : g_lane
    assign lanes[k] = vram_din[8*k +: 8];
  end

  logic   cas_n_old;
  logic   commit;
  logic   capture;
  vbyte_t cur_byte;
  vbyte_t push_byte;
  vbyte_t dl_oldest;

  // Commit on CAS rising inside RAS during a video slot.
  assign commit    = ~ras_n & ~cas_n_old & cas_n & cpu_n;
  assign capture   = ~ras_n & ~cas_n & cpu_n;
  assign cur_byte  = lanes[byte_idx];
  assign push_byte = de ? cur_byte : BLANK_BYTE;

  vram_delay_line #(
    .DEPTH (LINE_LEN)
  ) u_dline (
    .clk    (clk),
    .rst_n  (RESET_N),
    .push   (commit & shift_en),
    .din    (push_byte),
    .oldest (dl_oldest)
  );

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      cas_n_old  <= 1'b1;
      byte_idx   <= '0;
      fetch_done <= 1'b0;
      vram_d     <= BLANK_BYTE;
    end else begin
      cas_n_old  <= cas_n;
      fetch_done <= commit;
      // CPU slot resynchronises the word; commit already excludes cpu_n low.
      if (!cpu_n)
        byte_idx <= '0;
      else if (commit)
        byte_idx <= (byte_idx == LAST_IDX) ? '0 : byte_idx + 1'b1;
      // Capture and commit never share a cycle (CAS low vs high), so in shift
      // mode the read always sees the oldest entry before any push.
      if (capture)
        vram_d <= shift_en ? dl_oldest : cur_byte;
    end
  end

`ifdef VRAM_FETCH_COUNT_EN
  logic vsync_old;

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      vsync_old   <= 1'b0;
      fetch_count <= '0;
    end else begin
      vsync_old <= vsync;
      if (vsync & ~vsync_old)
        fetch_count <= '0;
      else if (commit && fetch_count != 16'hFFFF)
        fetch_count <= fetch_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vram_fetch_seq.sv
module tb_vram_fetch_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // DUT A: BPW=2, DELAY_CHARS=1
  logic        cpu2, ras2, cas2, de2, sh2;
  logic [15:0] din2;
  logic [7:0]  d2;
  logic [0:0]  idx2;
  logic        done2;
  // DUT B: BPW=4, DELAY_CHARS=1
  logic        cpu4, ras4, cas4, de4, sh4;
  logic [31:0] din4;
  logic [7:0]  d4;
  logic [1:0]  idx4;
  logic        done4;
`ifdef VRAM_FETCH_COUNT_EN
  logic        vsync2, vsync4;
  logic [15:0] cnt2, cnt4;
`endif

  vram_fetch_seq #(.BYTES_PER_WORD(2), .DELAY_CHARS(1)) dut2 (
    .clk(clk), .RESET_N(rst_n), .cpu_n(cpu2), .ras_n(ras2), .cas_n(cas2),
    .de(de2), .shift_en(sh2), .vram_din(din2),
`ifdef VRAM_FETCH_COUNT_EN
    .vsync(vsync2), .fetch_count(cnt2),
`endif
    .vram_d(d2), .byte_idx(idx2), .fetch_done(done2));

  vram_fetch_seq #(.BYTES_PER_WORD(4), .DELAY_CHARS(1)) dut4 (
    .clk(clk), .RESET_N(rst_n), .cpu_n(cpu4), .ras_n(ras4), .cas_n(cas4),
    .de(de4), .shift_en(sh4), .vram_din(din4),
`ifdef VRAM_FETCH_COUNT_EN
    .vsync(vsync4), .fetch_count(cnt4),
`endif
    .vram_d(d4), .byte_idx(idx4), .fetch_done(done4));

  typedef struct { logic [7:0] d; logic [1:0] idx; } exp_t;
  typedef struct {
    logic [15:0] din; logic de; logic sh; logic [7:0] exp_d; logic [1:0] exp_idx;
  } vec_t;

  exp_t q2[$];
  exp_t q4[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Advance to next falling edge and retire any completed fetch against the scoreboard.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (done2) begin
      if (q2.size() == 0) chk("done2_unexpected", 16'd1, 16'd0);
      else begin
        e = q2.pop_front();
        chk("vram_d2", {8'h0, d2}, {8'h0, e.d});
        chk("byte_idx2", {15'h0, idx2}, {14'h0, e.idx});
      end
    end
    if (done4) begin
      if (q4.size() == 0) chk("done4_unexpected", 16'd1, 16'd0);
      else begin
        e = q4.pop_front();
        chk("vram_d4", {8'h0, d4}, {8'h0, e.d});
        chk("byte_idx4", {14'h0, idx4}, {14'h0, e.idx});
      end
    end
  endtask

  // One CAS pulse inside RAS: capture cycle, then commit cycle.
  task automatic pulse2(input logic [15:0] w, input logic de, input logic sh,
                        input logic [7:0] ed, input logic [1:0] ei);
    exp_t e;
    e.d = ed; e.idx = ei;
    q2.push_back(e);
    din2 = w; de2 = de; sh2 = sh; cpu2 = 1'b1; ras2 = 1'b0; cas2 = 1'b0;
    tick();
    cas2 = 1'b1;
    tick();
  endtask

  task automatic pulse4(input logic [31:0] w, input logic [7:0] ed, input logic [1:0] ei);
    exp_t e;
    e.d = ed; e.idx = ei;
    q4.push_back(e);
    din4 = w; de4 = 1'b1; sh4 = 1'b0; cpu4 = 1'b1; ras4 = 1'b0; cas4 = 1'b0;
    tick();
    cas4 = 1'b1;
    tick();
  endtask

  vec_t tab[10];
  logic [7:0] exp4_d[4];
  logic [1:0] exp4_i[4];

  initial begin
    tab[0] = '{16'hA55A, 1'b1, 1'b0, 8'h5A, 2'd1};
    tab[1] = '{16'hA55A, 1'b1, 1'b0, 8'hA5, 2'd0};
    tab[2] = '{16'h1122, 1'b1, 1'b1, 8'h00, 2'd1};
    tab[3] = '{16'h1122, 1'b1, 1'b1, 8'h00, 2'd0};
    tab[4] = '{16'h3344, 1'b1, 1'b1, 8'h22, 2'd1};
    tab[5] = '{16'h3344, 1'b1, 1'b1, 8'h11, 2'd0};
    tab[6] = '{16'h5566, 1'b0, 1'b1, 8'h44, 2'd1};
    tab[7] = '{16'h5566, 1'b0, 1'b1, 8'h33, 2'd0};
    tab[8] = '{16'h7788, 1'b1, 1'b1, 8'h00, 2'd1};
    tab[9] = '{16'h7788, 1'b1, 1'b1, 8'h00, 2'd0};
    exp4_d = '{8'h11, 8'h22, 8'h33, 8'h44};
    exp4_i = '{2'd1, 2'd2, 2'd3, 2'd0};

    rst_n = 1'b0;
    cpu2 = 1'b1; ras2 = 1'b1; cas2 = 1'b1; de2 = 1'b1; sh2 = 1'b0; din2 = '0;
    cpu4 = 1'b1; ras4 = 1'b1; cas4 = 1'b1; de4 = 1'b1; sh4 = 1'b0; din4 = '0;
`ifdef VRAM_FETCH_COUNT_EN
    vsync2 = 1'b0; vsync4 = 1'b0;
`endif
    @(negedge clk);
    @(negedge clk);
    chk("rst_vram_d2", {8'h0, d2}, 16'h0);
    chk("rst_idx2", {15'h0, idx2}, 16'h0);
    chk("rst_done2", {15'h0, done2}, 16'h0);
    chk("rst_vram_d4", {8'h0, d4}, 16'h0);
    rst_n = 1'b1;
    tick();

    // Direct then shift sequences on the 2-byte instance.
    for (int i = 0; i < 10; i++)
      pulse2(tab[i].din, tab[i].de, tab[i].sh, tab[i].exp_d, tab[i].exp_idx);

    // 4-byte word split.
    for (int i = 0; i < 4; i++)
      pulse4(32'h44332211, exp4_d[i], exp4_i[i]);
    ras4 = 1'b1;

    // CPU slot after first byte resets the byte select.
    pulse2(16'hA55A, 1'b1, 1'b0, 8'h5A, 2'd1);
    cpu2 = 1'b0; cas2 = 1'b0;
    tick();
    cas2 = 1'b1;
    tick();
    chk("cpu_idx_clr", {15'h0, idx2}, 16'h0);
    chk("cpu_d_hold", {8'h0, d2}, 16'h005A);
    chk("cpu_no_done", {15'h0, done2}, 16'h0);
    pulse2(16'hA55A, 1'b1, 1'b0, 8'h5A, 2'd1);

    // Full delay line, nonzero output, then reset mid-RAS.
    pulse2(16'h99AA, 1'b1, 1'b1, 8'h88, 2'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_d2", {8'h0, d2}, 16'h0);
    chk("midrst_idx2", {15'h0, idx2}, 16'h0);
    chk("midrst_done2", {15'h0, done2}, 16'h0);
    chk("midrst_d4", {8'h0, d4}, 16'h0);
    tick();
    rst_n = 1'b1;
    pulse2(16'h99AA, 1'b1, 1'b1, 8'h00, 2'd1);
    pulse2(16'h99AA, 1'b1, 1'b1, 8'h00, 2'd0);
    pulse2(16'h99AA, 1'b1, 1'b1, 8'hAA, 2'd1);
    pulse2(16'h99AA, 1'b1, 1'b1, 8'h99, 2'd0);
    // Mode switch keeps line contents.
    pulse2(16'hBBCC, 1'b1, 1'b0, 8'hCC, 2'd1);
    pulse2(16'hBBCC, 1'b1, 1'b1, 8'hAA, 2'd0);

`ifdef VRAM_FETCH_COUNT_EN
    vsync2 = 1'b1;
    tick();
    vsync2 = 1'b0;
    tick();
    chk("cnt_vsync_clr", cnt2, 16'd0);
    for (int i = 0; i < 300; i++)
      pulse2(16'hA55A, 1'b1, 1'b0, (i % 2 == 0) ? 8'h5A : 8'hA5, (i % 2 == 0) ? 2'd1 : 2'd0);
    chk("cnt_300", cnt2, 16'd300);
    begin
      exp_t e;
      e.d = 8'h5A; e.idx = 2'd1;
      q2.push_back(e);
    end
    cas2 = 1'b0;
    tick();
    cas2 = 1'b1; vsync2 = 1'b1;
    tick();
    vsync2 = 1'b0;
    chk("cnt_clr_wins", cnt2, 16'd0);
    for (int i = 0; i < 70000; i++) begin
      @(negedge clk) cas2 = 1'b0;
      @(negedge clk) cas2 = 1'b1;
    end
    @(negedge clk);
    chk("cnt_sat", cnt2, 16'hFFFF);
`endif

    chk("scoreboard_drained", 16'(q2.size() + q4.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
